// File: rtl/idex_pipe_skid_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg : shared definitions for the ID/EX skid pipeline register.
//   - stage state encodings (value of each state equals its occupancy)
//   - default widths for control word, payload and PC fields
//   - bit positions of the control-word fields consumed by EX
// ---------------------------------------------------------------------------
package pipe_pkg;

  localparam int unsigned CTRL_W_DEF = 22;
  localparam int unsigned DATA_W_DEF = 128;
  localparam int unsigned PC_W_DEF   = 9;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  // Control-word field positions
  localparam int unsigned CTRL_SRC_OP_HI = 17;
  localparam int unsigned CTRL_SRC_OP_LO = 15;
  localparam int unsigned CTRL_ALU_OP_HI = 14;
  localparam int unsigned CTRL_ALU_OP_LO = 11;
  localparam int unsigned CTRL_LOAD      = 10;
  localparam int unsigned CTRL_RF_EN     = 9;
  localparam int unsigned CTRL_BRANCH    = 8;
  localparam int unsigned CTRL_HI        = 2;
  localparam int unsigned CTRL_LO        = 1;

  // Entries held in a given state
  function automatic logic [1:0] state_occupancy(input pipe_state_e s);
    return logic'(s == ST_FULL) ? 2'd2 : ((s == ST_ONE) ? 2'd1 : 2'd0);
  endfunction

endpackage

// File: rtl/idex_pipe_skid_if.sv
// ---------------------------------------------------------------------------
// idex_pipe_skid_if : decode -> EX handshake bundle.
//   in_valid/in_ready/in_ctrl/in_data/in_pc/in_pc8 : decode side
//   flush                                          : squash request
//   out_valid/out_ready/out_ctrl/out_data/out_pc/out_pc8 : EX side
// modport master : the environment (decode + EX + squash source)
// modport slave  : the pipeline stage itself
// ---------------------------------------------------------------------------
interface idex_pipe_skid_if
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned PC_W   = PC_W_DEF
);

  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic [PC_W-1:0]   in_pc;
  logic [PC_W-1:0]   in_pc8;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [PC_W-1:0]   out_pc;
  logic [PC_W-1:0]   out_pc8;

  modport master (
    output in_valid, in_ctrl, in_data, in_pc, in_pc8, flush, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data, out_pc, out_pc8
  );

  modport slave (
    input  in_valid, in_ctrl, in_data, in_pc, in_pc8, flush, out_ready,
    output in_ready, out_valid, out_ctrl, out_data, out_pc, out_pc8
  );

endinterface

// File: rtl/idex_pipe_skid_perf_ctr.sv
// ---------------------------------------------------------------------------
// pipe_perf_ctr : saturating event counter.
//   clk, reset (async, active-high) : clock / clear
//   inc                             : count this cycle
//   count                           : current value, sticks at all-ones
// ---------------------------------------------------------------------------
module pipe_perf_ctr #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/idex_pipe_skid.sv
// ---------------------------------------------------------------------------
// idex_pipe_skid : ID/EX pipeline register with valid/ready handshake and a
// one-entry skid buffer (two entries total), stall and flush support.
//   clk, reset     : clock, asynchronous active-high reset
//   bus (slave)    : decode inputs, EX outputs, flush (see idex_pipe_skid_if)
//   occupancy      : entries held (0, 1, 2)
//   stall_cycles   : out_valid & !out_ready cycles   (PIPE_PERF_CNT_EN only)
//   bubble_cycles  : !out_valid & out_ready cycles   (PIPE_PERF_CNT_EN only)
// Optional feature macro: PIPE_PERF_CNT_EN (performance counters).
// The main register always drives the outputs; the skid register only holds
// the entry accepted while EX was stalled. in_ready is registered.
// ---------------------------------------------------------------------------
module idex_pipe_skid
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned PC_W   = PC_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  idex_pipe_skid_if.slave      bus,
  output logic [1:0]           occupancy
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]          stall_cycles,
  output logic [31:0]          bubble_cycles
`endif
);

  pipe_state_e       state, state_nx;
  logic              in_ready_q;
  logic              out_valid;
  logic              in_fire, out_fire;
  logic              ld_main_in, ld_main_skid, ld_skid;

  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [PC_W-1:0]   main_pc,   skid_pc;
  logic [PC_W-1:0]   main_pc8,  skid_pc8;

  assign out_valid = (state != ST_EMPTY);
  assign in_fire   = bus.in_valid & in_ready_q;
  assign out_fire  = out_valid & bus.out_ready;

  // Next-state and register load selects
  always_comb begin
    state_nx     = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    unique case (state)
      ST_EMPTY: begin
        if (in_fire) begin
          ld_main_in = 1'b1;
          state_nx   = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          ld_main_in = 1'b1;
        end else if (in_fire) begin
          ld_skid  = 1'b1;
          state_nx = ST_FULL;
        end else if (out_fire) begin
          state_nx = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          ld_main_skid = 1'b1;
          state_nx     = ST_ONE;
        end
      end
      default: state_nx = ST_EMPTY;
    endcase
    // Squash overrides everything; an accepted input is discarded, while a
    // concurrent consume has already happened on the EX side.
    if (bus.flush) begin
      state_nx     = ST_EMPTY;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_nx;
      in_ready_q <= (state_nx != ST_FULL);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_ctrl <= '0;
      main_data <= '0;
      main_pc   <= '0;
      main_pc8  <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
      skid_pc   <= '0;
      skid_pc8  <= '0;
    end else begin
      if (ld_main_in) begin
        main_ctrl <= bus.in_ctrl;
        main_data <= bus.in_data;
        main_pc   <= bus.in_pc;
        main_pc8  <= bus.in_pc8;
      end else if (ld_main_skid) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
        main_pc   <= skid_pc;
        main_pc8  <= skid_pc8;
      end
      if (ld_skid) begin
        skid_ctrl <= bus.in_ctrl;
        skid_data <= bus.in_data;
        skid_pc   <= bus.in_pc;
        skid_pc8  <= bus.in_pc8;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid;
  assign bus.out_ctrl  = out_valid ? main_ctrl : '0;
  assign bus.out_data  = main_data;
  assign bus.out_pc    = main_pc;
  assign bus.out_pc8   = main_pc8;
  assign occupancy     = state_occupancy(state);

`ifdef PIPE_PERF_CNT_EN
  pipe_perf_ctr #(.WIDTH(32)) u_stall_ctr (
    .clk   (clk),
    .reset (reset),
    .inc   (out_valid & ~bus.out_ready),
    .count (stall_cycles)
  );

  pipe_perf_ctr #(.WIDTH(32)) u_bubble_ctr (
    .clk   (clk),
    .reset (reset),
    .inc   (~out_valid & bus.out_ready),
    .count (bubble_cycles)
  );
`endif

endmodule

// File: doc/idex_pipe_skid.md
Name: idex_pipe_skid

Overview:
- Parametrised successor to the ID/EX pipeline register.
- Carries a control word, data payload and PC from decode to execute through a valid/ready handshake with a 2-entry skid buffer.
- Adds stall (backpressure) and flush (branch squash) support; the control word is forced to zero (NOP) whenever no valid entry is presented.
- Sits between the decode stage and the EX stage/condition handler.

Parameters:
- CTRL_W, 22, control-word width (ALU op, load, RF enable, branch, source-operand fields).
- DATA_W, 128, packed payload width (operands A/B/C, PB, imm16, rd/rt/r31, target address).
- PC_W, 9, width of PC and PC+8 fields, each carried separately.

Ports:
- clk  in  1  clock.
- reset  in  1  reset; asynchronous, active-high.
- in_valid  in  1  decode presents an entry.
- in_ready  out  1  stage can accept; registered, equals NOT full.
- in_ctrl  in  CTRL_W  decode control word.
- in_data  in  DATA_W  decode payload.
- in_pc  in  PC_W  decode PC.
- in_pc8  in  PC_W  decode PC+8.
- flush  in  1  synchronous squash of all held entries.
- out_valid  out  1  EX entry valid.
- out_ready  in  1  EX consumes the entry.
- out_ctrl  out  CTRL_W  EX control word; zero when out_valid=0.
- out_data  out  DATA_W  EX payload.
- out_pc  out  PC_W  EX PC.
- out_pc8  out  PC_W  EX PC+8.
- occupancy  out  2  number of entries held: 0, 1 or 2.
- stall_cycles  out  32  present only with PIPE_PERF_CNT_EN.
- bubble_cycles  out  32  present only with PIPE_PERF_CNT_EN.

Behaviour:
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: a main register drives all outputs; a skid register holds one overflow entry.
- States: EMPTY (0 entries), ONE (main valid), FULL (main and skid valid).
- EMPTY: in_fire -> main<=in, go to ONE.
- ONE, in_fire & out_fire: main<=in, stay in ONE.
- ONE, in_fire & !out_fire: skid<=in, go to FULL.
- ONE, !in_fire & out_fire: go to EMPTY.
- ONE, otherwise: hold.
- FULL: in_ready=0, so no in_fire. out_fire -> main<=skid, go to ONE. Otherwise hold.
- in_ready is registered: low exactly while in FULL; it never depends combinationally on out_ready.
- Latency: 1 cycle from in_fire into EMPTY to out_valid. Sustained throughput is 1 entry/cycle in ONE.
- Ordering: strict FIFO. The skid entry is never overtaken.
- out_ctrl = main_ctrl when out_valid, else all zeros. out_data/out_pc/out_pc8 hold their last value when invalid.
- flush: the next state is EMPTY regardless of the current state. A concurrent in_fire is dropped. A concurrent out_fire still counts as consumed by EX. flush has priority over every transition.
- Reset (asynchronous, at any time including mid-transfer):
  - state=EMPTY, out_valid=0, in_ready=1.
  - out_ctrl, out_data, out_pc, out_pc8 = 0; skid contents = 0; occupancy = 0; counters = 0.
- in_valid or in_ready while reset is asserted: no effect.
- occupancy equals the state encoding: EMPTY=0, ONE=1, FULL=2.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- With the macro:
  - stall_cycles increments on each cycle with out_valid=1 & out_ready=0.
  - bubble_cycles increments on each cycle with out_valid=0 & out_ready=1.
  - Both saturate at 32'hFFFF_FFFF and are cleared only by reset; flush does not clear them.
- Without the macro: both ports and all counter logic are absent; the datapath behaves identically.

Decomposition:
- Package pipe_pkg holds:
  - state encodings ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2;
  - default CTRL_W/DATA_W/PC_W;
  - control-word field indices: alu_op [14:11], load [10], rf_en [9], branch [8], src_op [17:15], hi [2], lo [1].
- One sub-module, pipe_perf_ctr: 32-bit saturating counter with increment enable. Instantiated twice, only under PIPE_PERF_CNT_EN.

Test Plan:
- Reset and single entry:
  - Assert reset mid-cycle -> outputs zero immediately, in_ready=1, occupancy=0.
  - Release reset, in_ctrl=22'h3FFFFF, in_pc=9'h1A0, one-cycle in_valid with out_ready=1 -> next cycle out_valid=1, out_ctrl=22'h3FFFFF, out_pc=9'h1A0; following cycle out_valid=0, out_ctrl=0.
- Backpressure fill and drain:
  - out_ready=0; push A (pc=1) then B (pc=2) -> occupancy=2, in_ready=0, out_pc=1; C held at input is not accepted.
  - Raise out_ready -> out_pc sequence 1, 2, 3 on consecutive cycles, with no loss or duplication.
- Streaming: in_valid=1 and out_ready=1 for 20 cycles with pc incrementing -> out_pc increments each cycle after 1-cycle latency; in_ready stays 1.
- Flush while FULL with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1; the concurrent input never appears at the output.
- Reset mid-stream: assert reset while in FULL -> everything clears asynchronously; after release the first new entry appears with 1-cycle latency.
- With PIPE_PERF_CNT_EN:
  - 5 stall cycles then 3 bubble cycles -> stall_cycles=5, bubble_cycles=3.
  - Force counter to 32'hFFFF_FFFF plus further stalls -> value holds at saturation.
